// File: rtl/shrv32_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package shrv32_boot_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE_S,
        ERR_S
    } boot_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef logic [15:0] word_count_t;

    // States in which the loader is willing to take a byte from the receiver.
    function automatic logic rx_open(input boot_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_writer_if.sv
// Byte-stream input, instruction RAM write port and boot status of the loader.
interface imem_boot_writer_if;
    import shrv32_boot_pkg::*;

    logic [BYTE_W-1:0] RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              WE;
    logic [31:0]       A;
    logic [WORD_W-1:0] WD;
    logic              CPU_HOLD;
    logic              DONE;
    logic              ERR;

    modport master (
        output RX_DATA, RX_VALID,
        input  RX_READY, WE, A, WD, CPU_HOLD, DONE, ERR
    );

    modport slave (
        input  RX_DATA, RX_VALID,
        output RX_READY, WE, A, WD, CPU_HOLD, DONE, ERR
    );

endinterface

// File: rtl/boot_word_assembler.sv
// Collects bytes into little-endian 32-bit words, one lane per accepted byte.
module boot_word_assembler
    import shrv32_boot_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              take,
    output logic              last_lane_c,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full
);

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] lanes_q;
    logic              full_q;

    assign last_lane_c = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_full   = full_q;

    // Word including the byte arriving this cycle, so a finished word is visible at once.
    always_comb begin
        word_c = lanes_q;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_valid && (lane_q == LANE_W'(k))) begin
                word_c[k*BYTE_W +: BYTE_W] = byte_in;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_q  <= '0;
            lanes_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (byte_valid) begin
                lanes_q <= word_c;
                lane_q  <= lane_q + LANE_W'(1);
            end
            if (byte_valid && last_lane_c) begin
                full_q <= 1'b1;
            end else if (take) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imem_boot_writer.sv
// Loads a length-prefixed, XOR-checksummed image from the UART into instruction RAM
// and releases the core only once the whole image has been verified.
module imem_boot_writer
    import shrv32_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    imem_boot_writer_if.slave bus
);

    boot_state_t       state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [31:0]       a_q, a_d;
    logic [WORD_W-1:0] wd_q, wd_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    word_count_t       idx_q, idx_d;
    word_count_t       n_q, n_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [BYTE_W-1:0] xor_q, xor_d;

    logic              accept_c;
    word_count_t       n_rx_c;
    logic              last_lane_c;
    logic [WORD_W-1:0] word_c;
    logic              word_full;

    assign accept_c = bus.RX_VALID && rdy_q;
    assign n_rx_c   = {bus.RX_DATA, len_lo_q};

    boot_word_assembler u_asm (
        .CLK         (CLK),
        .RST         (RST),
        .byte_valid  (accept_c && (state_q == DATA)),
        .byte_in     (bus.RX_DATA),
        .take        ((state_q == WRITE) && word_full),
        .last_lane_c (last_lane_c),
        .word_c      (word_c),
        .word_full   (word_full)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        a_d      = a_q;
        wd_d     = wd_q;
        idx_d    = idx_q;
        n_d      = n_q;
        len_lo_d = len_lo_q;
        xor_d    = xor_q;

        case (state_q)
            LEN_LO: begin
                if (accept_c) begin
                    len_lo_d = bus.RX_DATA;
                    xor_d    = xor_q ^ bus.RX_DATA;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept_c) begin
                    n_d   = n_rx_c;
                    xor_d = xor_q ^ bus.RX_DATA;
                    if (32'(n_rx_c) > 32'(MAX_WORDS)) begin
                        state_d = ERR_S;
                    end else if (n_rx_c == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
                    xor_d = xor_q ^ bus.RX_DATA;
                    // Write port is loaded on the same edge that takes the last byte.
                    if (last_lane_c) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        a_d     = BASE_ADDR + (32'(idx_q) << 2);
                        wd_d    = word_c;
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + word_count_t'(1);
                state_d = (idx_q + word_count_t'(1) == n_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept_c) begin
                    state_d = (bus.RX_DATA == xor_q) ? DONE_S : ERR_S;
                end
            end
            DONE_S:  state_d = DONE_S;
            ERR_S:   state_d = ERR_S;
            default: state_d = LEN_LO;
        endcase

        rdy_d  = rx_open(state_d);
        hold_d = (state_d != DONE_S);
        done_d = (state_d == DONE_S);
        err_d  = (state_d == ERR_S);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= LEN_LO;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            a_q      <= BASE_ADDR;
            wd_q     <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            n_q      <= '0;
            len_lo_q <= '0;
            xor_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            we_q     <= we_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            len_lo_q <= len_lo_d;
            xor_q    <= xor_d;
        end
    end

    assign bus.RX_READY = rdy_q;
    assign bus.WE       = we_q;
    assign bus.A        = a_q;
    assign bus.WD       = wd_q;
    assign bus.CPU_HOLD = hold_q;
    assign bus.DONE     = done_q;
    assign bus.ERR      = err_q;

endmodule

// File: tb/tb_imem_boot_writer.sv
// Directed bench for imem_boot_writer: two instances, base address 0 and 0x100.
module tb_imem_boot_writer;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    imem_boot_writer_if bus0 ();
    imem_boot_writer_if bus1 ();

    imem_boot_writer #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    imem_boot_writer #(.BASE_ADDR(32'h100), .MAX_WORDS(1024)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] q0_a[$];
    logic [31:0] q0_d[$];
    logic [31:0] q1_a[$];
    logic [31:0] q1_d[$];
    int          rdy_viol = 0;
    int          bb_viol  = 0;
    logic        prev_we0 = 1'b0;
    logic [7:0]  frame[$];

    // Record every write strobe and flag illegal READY/back-to-back strobes.
    always @(negedge CLK) begin
        if (bus0.WE === 1'b1) begin
            q0_a.push_back(bus0.A);
            q0_d.push_back(bus0.WD);
            if (bus0.RX_READY !== 1'b0) rdy_viol++;
            if (prev_we0 === 1'b1) bb_viol++;
        end
        if (bus1.WE === 1'b1) begin
            q1_a.push_back(bus1.A);
            q1_d.push_back(bus1.WD);
        end
        prev_we0 = bus0.WE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic [7:0] b, input logic v);
        if (which == 0) begin
            bus0.RX_DATA  = b;
            bus0.RX_VALID = v;
        end else begin
            bus1.RX_DATA  = b;
            bus1.RX_VALID = v;
        end
    endtask

    task automatic send(input int which, input logic [7:0] b, input int idle);
        logic acc;
        acc = 1'b0;
        if (idle > 0) begin
            drive(which, 8'h00, 1'b0);
            repeat (idle) @(posedge CLK);
            #1;
        end
        drive(which, b, 1'b1);
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge CLK);
            acc = (which == 0) ? bus0.RX_READY : bus1.RX_READY;
            @(posedge CLK);
            #1;
        end
        drive(which, 8'h00, 1'b0);
        check("byte_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input int which, input int max_idle);
        foreach (frame[i]) begin
            send(which, frame[i], (max_idle == 0) ? 0 : int'($urandom_range(0, max_idle)));
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        q0_a.delete(); q0_d.delete(); q1_a.delete(); q1_d.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic check_t1_trace(input string tag);
        check({tag, "_nwe"}, 32'(q0_a.size()), 32'd2);
        if (q0_a.size() == 2) begin
            check({tag, "_a0"}, q0_a[0], 32'h0000_0000);
            check({tag, "_d0"}, q0_d[0], 32'h0102_0304);
            check({tag, "_a1"}, q0_a[1], 32'h0000_0004);
            check({tag, "_d1"}, q0_d[1], 32'h0506_0708);
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_done"}, 32'(bus0.DONE), 32'(done));
        check({tag, "_err"},  32'(bus0.ERR),  32'(err));
        check({tag, "_hold"}, 32'(bus0.CPU_HOLD), 32'(hold));
    endtask

    initial begin
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        repeat (2) @(posedge CLK);
        #1;

        // Reset values while RST is high.
        check("rst_ready", 32'(bus0.RX_READY), 32'd0);
        check("rst_we",    32'(bus0.WE), 32'd0);
        check("rst_a",     bus0.A, 32'h0);
        check("rst_wd",    bus0.WD, 32'h0);
        check("rst_hold",  32'(bus0.CPU_HOLD), 32'd1);
        check("rst_done",  32'(bus0.DONE), 32'd0);
        check("rst_err",   32'(bus0.ERR), 32'd0);
        check("rst_a_base", bus1.A, 32'h100);
        RST = 1'b0;
        check("ready_before_clk", 32'(bus0.RX_READY), 32'd0);
        @(posedge CLK); #1;
        check("ready_after_clk", 32'(bus0.RX_READY), 32'd1);

        // 1: two-word image, good checksum.
        do_reset();
        frame = '{8'h02, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h0A};
        send_frame(0, 0);
        check_t1_trace("t1");
        check_status("t1", 1'b1, 1'b0, 1'b0);
        check("t1_ready_done", 32'(bus0.RX_READY), 32'd0);

        // 2: same image, bad checksum.
        do_reset();
        frame = '{8'h02, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h0B};
        send_frame(0, 0);
        check_t1_trace("t2");
        check_status("t2", 1'b0, 1'b1, 1'b1);

        // 3a: empty image.
        do_reset();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0, 0);
        check("t3_nwe", 32'(q0_a.size()), 32'd0);
        check_status("t3a", 1'b1, 1'b0, 1'b0);

        // 3b: length 1025 exceeds the limit and errors right after the high length byte.
        do_reset();
        send(0, 8'h01, 0);
        send(0, 8'h04, 0);
        check_status("t3b", 1'b0, 1'b1, 1'b1);
        check("t3b_ready", 32'(bus0.RX_READY), 32'd0);

        // 4: random idle gaps between bytes.
        do_reset();
        rdy_viol = 0;
        bb_viol  = 0;
        frame = '{8'h02, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h0A};
        send_frame(0, 5);
        check_t1_trace("t4");
        check_status("t4", 1'b1, 1'b0, 1'b0);
        check("t4_ready_in_write", 32'(rdy_viol), 32'd0);
        check("t4_back_to_back", 32'(bb_viol), 32'd0);

        // 5: reset in the middle of the second word, then the full frame again.
        do_reset();
        frame = '{8'h02, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07};
        send_frame(0, 0);
        check("t5_pre_nwe", 32'(q0_a.size()), 32'd1);
        RST = 1'b1;
        #1;
        check("t5_rst_wd",    bus0.WD, 32'h0);
        check("t5_rst_a",     bus0.A, 32'h0);
        check("t5_rst_ready", 32'(bus0.RX_READY), 32'd0);
        check("t5_rst_we",    32'(bus0.WE), 32'd0);
        check_status("t5_rst", 1'b0, 1'b0, 1'b1);
        do_reset();
        frame = '{8'h02, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h0A};
        send_frame(0, 0);
        check_t1_trace("t5");
        check_status("t5", 1'b1, 1'b0, 1'b0);

        // 6: three words at base 0x100, then bytes after DONE are refused.
        do_reset();
        frame = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        send_frame(1, 0);
        check("t6_nwe", 32'(q1_a.size()), 32'd3);
        if (q1_a.size() == 3) begin
            check("t6_a0", q1_a[0], 32'h100);
            check("t6_d0", q1_d[0], 32'h4433_2211);
            check("t6_a1", q1_a[1], 32'h104);
            check("t6_d1", q1_d[1], 32'h8877_6655);
            check("t6_a2", q1_a[2], 32'h108);
            check("t6_d2", q1_d[2], 32'hCCBB_AA99);
        end
        check("t6_done", 32'(bus1.DONE), 32'd1);
        check("t6_hold", 32'(bus1.CPU_HOLD), 32'd0);
        drive(1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t6_ready_after_done", 32'(bus1.RX_READY), 32'd0);
        end
        drive(1, 8'h00, 1'b0);
        check("t6_done_stays", 32'(bus1.DONE), 32'd1);
        check("t6_err_clear", 32'(bus1.ERR), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
